// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage:
// FSM states, byte-enable patterns and the access-size encoding.
package mem_access_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } acc_size_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // Byte wins over Half when both control bits are set.
    function automatic acc_size_e acc_size(input logic is_byte, input logic is_half);
        if (is_byte) return SZ_BYTE;
        if (is_half) return SZ_HALF;
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed little-endian lane of a loaded word and
// zero- or sign-extends it to 32 bits; word loads pass unmodified.
module load_extend (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic        Byte,
    input  logic        Half,
    input  logic        UnsignedExt,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
    end

    always_comb begin
        data = rdata;
        if (Byte)
            data = {{24{~UnsignedExt & byte_lane[7]}}, byte_lane};
        else if (Half)
            data = {{16{~UnsignedExt & half_lane[15]}}, half_lane};
    end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM -> MEM/WB stage: issues data-memory requests, stalls until dm_ack.
// Optional MEM_MISALIGN_TRAP_EN adds a registered Misalign output.
//
// Handshake: dm_req is held with stable address/data until dm_ack=1 is seen
// on a rising edge; that edge completes the access. Upstream holds all *_in
// stable while Stall=1.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic              In,
    input  logic [DATA_W-1:0] IR_in,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] R1_in,
    input  logic [DATA_W-1:0] R2_in,
    input  logic [DATA_W-1:0] RD2_in,
    input  logic [4:0]        WbRegNum_in,
    input  logic              RegWrite_in,
    input  logic              LOWrite_in,
    input  logic              HIWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemWrite_in,
    input  logic              UnsignedExt_Mem_in,
    input  logic              Byte_in,
    input  logic              Half_in,
    output logic              Stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              Out,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] MemData,
    output logic [4:0]        WbRegNum,
    output logic              RegWrite,
    output logic              LOWrite,
    output logic              HIWrite,
    output logic              MemtoReg,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              Misalign,
`endif
    output mem_state_e        state_dbg
);

    mem_state_e  state;
    acc_size_e   size;
    logic        mem_op;
    logic        access;
    logic        trap_block;
    logic        load_done;
    logic [31:0] ld_data;

    assign size   = acc_size(Byte_in, Half_in);
    assign mem_op = In & (MemtoReg_in | MemWrite_in);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = mem_op & (((size == SZ_HALF) & R1_in[0]) |
                                  ((size == SZ_WORD) & (|R1_in[1:0])));
    assign access     = mem_op & ~misaligned;
    assign trap_block = misaligned;
`else
    assign access     = mem_op;
    assign trap_block = 1'b0;
`endif

    assign dm_req    = (state == ST_WAIT) | ((state == ST_IDLE) & access);
    assign dm_we     = dm_req & MemWrite_in;
    assign Stall     = dm_req & ~dm_ack;
    assign dm_addr   = {R1_in[31:2], 2'b00};
    assign load_done = dm_req & dm_ack & MemtoReg_in & ~MemWrite_in;
    assign state_dbg = state;

    always_comb begin
        dm_be    = BE_WORD;
        dm_wdata = RD2_in;
        case (size)
            SZ_BYTE: begin
                dm_be    = 4'b0001 << R1_in[1:0];
                dm_wdata = {4{RD2_in[7:0]}};
            end
            SZ_HALF: begin
                dm_be    = R1_in[1] ? BE_HALF_HI : BE_HALF_LO;
                dm_wdata = {2{RD2_in[15:0]}};
            end
            default: begin
                dm_be    = BE_WORD;
                dm_wdata = RD2_in;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata       (dm_rdata),
        .addr        (R1_in[1:0]),
        .Byte        (Byte_in),
        .Half        (Half_in),
        .UnsignedExt (UnsignedExt_Mem_in),
        .data        (ld_data)
    );

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state    <= ST_IDLE;
            Out      <= 1'b0;
            IR       <= '0;
            PC       <= '0;
            R1       <= '0;
            R2       <= '0;
            MemData  <= '0;
            WbRegNum <= '0;
            RegWrite <= 1'b0;
            LOWrite  <= 1'b0;
            HIWrite  <= 1'b0;
            MemtoReg <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            Misalign <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (access && !dm_ack) state <= ST_WAIT;
                ST_WAIT: if (dm_ack) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // A stalled edge emits a bubble; data fields keep their last value.
            if (Stall) begin
                Out      <= 1'b0;
                RegWrite <= 1'b0;
                LOWrite  <= 1'b0;
                HIWrite  <= 1'b0;
                MemtoReg <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                Misalign <= 1'b0;
`endif
            end else begin
                Out      <= In;
                IR       <= IR_in;
                PC       <= PC_in;
                R1       <= R1_in;
                R2       <= R2_in;
                WbRegNum <= WbRegNum_in;
                MemData  <= load_done ? ld_data : '0;
                RegWrite <= In & RegWrite_in & ~trap_block;
                LOWrite  <= In & LOWrite_in;
                HIWrite  <= In & HIWrite_in;
                MemtoReg <= In & MemtoReg_in & ~trap_block;
`ifdef MEM_MISALIGN_TRAP_EN
                Misalign <= misaligned;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level model and
// scoreboard queue; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    typedef struct {
        logic        in;
        logic [31:0] ir, pc, r1, r2, rd2, rdata;
        logic [4:0]  wb;
        logic        rw, lo, hi, m2r, mw, uext, byt, half, spur;
        int          w;
    } txn_t;

    typedef struct {
        logic        out;
        logic [31:0] ir, pc, r1, r2, md;
        logic [4:0]  wb;
        logic        rw, lo, hi, m2r, mis;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    logic in_s, rw_in, lo_in, hi_in, m2r_in, mw_in, uext_in, byte_in, half_in;
    logic [31:0] ir_in, pc_in, r1_in, r2_in, rd2_in;
    logic [4:0]  wb_in;
    logic        stall, dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        out_o, rw_o, lo_o, hi_o, m2r_o, mis_o;
    logic [31:0] ir_o, pc_o, r1_o, r2_o, md_o;
    logic [4:0]  wb_o;
    mem_state_e  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];
    exp_t last;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    int          obs_stalls;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
    assign mis_o = 1'b0;
`endif

    mem_access_stage #(.DATA_W(32)) dut (
        .clk(clk), .CLR(clr), .In(in_s),
        .IR_in(ir_in), .PC_in(pc_in), .R1_in(r1_in), .R2_in(r2_in), .RD2_in(rd2_in),
        .WbRegNum_in(wb_in), .RegWrite_in(rw_in), .LOWrite_in(lo_in), .HIWrite_in(hi_in),
        .MemtoReg_in(m2r_in), .MemWrite_in(mw_in), .UnsignedExt_Mem_in(uext_in),
        .Byte_in(byte_in), .Half_in(half_in),
        .Stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .Out(out_o), .IR(ir_o), .PC(pc_o), .R1(r1_o), .R2(r2_o), .MemData(md_o),
        .WbRegNum(wb_o), .RegWrite(rw_o), .LOWrite(lo_o), .HIWrite(hi_o), .MemtoReg(m2r_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .Misalign(mis_o),
`endif
        .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: spec rules as plain arithmetic
    function automatic logic model_misal(input txn_t t);
        logic [1:0] a = t.r1[1:0];
        if (!TRAP || !t.in || !(t.m2r || t.mw) || t.byt) return 1'b0;
        if (t.half) return a[0];
        return a != 2'd0;
    endfunction

    function automatic logic [3:0] model_be(input txn_t t);
        int a = int'(t.r1[1:0]);
        if (t.byt)  return 4'(1 << a);
        if (t.half) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input txn_t t);
        if (t.byt)  return {24'h0, t.rd2[7:0]} * 32'h0101_0101;
        if (t.half) return {16'h0, t.rd2[15:0]} * 32'h0001_0001;
        return t.rd2;
    endfunction

    function automatic logic [31:0] model_load(input txn_t t);
        int a = int'(t.r1[1:0]);
        logic [31:0] v;
        if (t.byt) begin
            v = (t.rdata >> (a * 8)) & 32'hFF;
            if (!t.uext && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (t.half) begin
            v = (t.rdata >> ((a / 2) * 16)) & 32'hFFFF;
            if (!t.uext && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = t.rdata;
        end
        return v;
    endfunction

    function automatic txn_t blank_txn();
        txn_t t;
        t.in = 0; t.ir = 0; t.pc = 0; t.r1 = 0; t.r2 = 0; t.rd2 = 0; t.rdata = 0;
        t.wb = 0; t.rw = 0; t.lo = 0; t.hi = 0; t.m2r = 0; t.mw = 0;
        t.uext = 0; t.byt = 0; t.half = 0; t.spur = 0; t.w = 0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t = blank_txn();
        int kind = $urandom_range(0, 2);
        t.in = ($urandom_range(0, 9) != 0);
        t.ir = $urandom; t.pc = $urandom; t.r1 = $urandom; t.r2 = $urandom;
        t.rd2 = $urandom; t.rdata = $urandom; t.wb = 5'($urandom);
        t.lo = 1'($urandom); t.hi = 1'($urandom); t.uext = 1'($urandom);
        t.byt = ($urandom_range(0, 2) == 0);
        t.half = 1'($urandom);
        t.m2r = (kind == 1);
        t.mw  = (kind == 2);
        t.rw  = (kind == 2) ? 1'b0 : 1'($urandom);
        t.spur = 1'($urandom);
        t.w = $urandom_range(0, 3);
        return t;
    endfunction

    // Driver: presents one instruction and plays the memory for t.w wait cycles
    task automatic drive(input txn_t t);
        logic acc, mis, stall_e;
        int waited = 0;
        exp_t e;
        @(negedge clk);
        in_s = t.in; ir_in = t.ir; pc_in = t.pc; r1_in = t.r1; r2_in = t.r2;
        rd2_in = t.rd2; wb_in = t.wb; rw_in = t.rw; lo_in = t.lo; hi_in = t.hi;
        m2r_in = t.m2r; mw_in = t.mw; uext_in = t.uext; byte_in = t.byt;
        half_in = t.half; dm_rdata = t.rdata;
        mis = model_misal(t);
        acc = t.in && (t.m2r || t.mw) && !mis;
        obs_stalls = 0;
        for (int k = 0; k < 8; k++) begin
            dm_ack  = acc ? (waited == t.w) : t.spur;
            stall_e = acc && (waited < t.w);
            #1;
            chk("dm_req", 32'(dm_req), 32'(acc));
            chk("stall", 32'(stall), 32'(stall_e));
            chk("state", 32'(state_dbg), (waited > 0) ? 32'(ST_WAIT) : 32'(ST_IDLE));
            if (acc) begin
                chk("dm_we", 32'(dm_we), 32'(t.mw));
                chk("dm_addr", dm_addr, t.r1 & 32'hFFFF_FFFC);
                chk("dm_be", 32'(dm_be), 32'(model_be(t)));
                if (t.mw) chk("dm_wdata", dm_wdata, model_wdata(t));
            end
            if (k == 0) begin
                obs_be = dm_be;
                obs_wdata = dm_wdata;
            end
            if (stall) obs_stalls++;
            if (stall_e) begin
                e = last;
                e.out = 0; e.rw = 0; e.lo = 0; e.hi = 0; e.m2r = 0; e.mis = 0;
            end else begin
                e.out = t.in; e.ir = t.ir; e.pc = t.pc; e.r1 = t.r1; e.r2 = t.r2;
                e.wb = t.wb;
                e.rw  = t.in && t.rw && !mis;
                e.lo  = t.in && t.lo;
                e.hi  = t.in && t.hi;
                e.m2r = t.in && t.m2r && !mis;
                e.mis = mis;
                e.md  = (acc && t.m2r && !t.mw) ? model_load(t) : 32'h0;
            end
            last = e;
            exp_q.push_back(e);
            @(posedge clk);
            if (!stall_e) break;
            waited++;
            @(negedge clk);
        end
    endtask

    task automatic zero_last();
        last.out = 0; last.ir = 0; last.pc = 0; last.r1 = 0; last.r2 = 0;
        last.md = 0; last.wb = 0; last.rw = 0; last.lo = 0; last.hi = 0;
        last.m2r = 0; last.mis = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_out"}, 32'(out_o), 0);
        chk({nm, "_ir"}, ir_o, 0);
        chk({nm, "_pc"}, pc_o, 0);
        chk({nm, "_r1"}, r1_o, 0);
        chk({nm, "_r2"}, r2_o, 0);
        chk({nm, "_md"}, md_o, 0);
        chk({nm, "_wb"}, 32'(wb_o), 0);
        chk({nm, "_we"}, {27'h0, rw_o, lo_o, hi_o, m2r_o, mis_o}, 0);
        chk({nm, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    // Scoreboard: one entry per rising edge the driver produced
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_out", 32'(out_o), 32'(e.out));
                chk("sb_ir", ir_o, e.ir);
                chk("sb_pc", pc_o, e.pc);
                chk("sb_r1", r1_o, e.r1);
                chk("sb_r2", r2_o, e.r2);
                chk("sb_memdata", md_o, e.md);
                chk("sb_wbreg", 32'(wb_o), 32'(e.wb));
                chk("sb_enables", {28'h0, rw_o, lo_o, hi_o, m2r_o},
                    {28'h0, e.rw, e.lo, e.hi, e.m2r});
                if (TRAP) chk("sb_misalign", 32'(mis_o), 32'(e.mis));
            end
        end
    end

    initial begin
        txn_t t;
        exp_t z;
        clr = 1'b1; in_s = 0; ir_in = 0; pc_in = 0; r1_in = 0; r2_in = 0; rd2_in = 0;
        wb_in = 0; rw_in = 0; lo_in = 0; hi_in = 0; m2r_in = 0; mw_in = 0;
        uext_in = 0; byte_in = 0; half_in = 0; dm_ack = 0; dm_rdata = 0;
        zero_last();
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) clr = 1'b0;

        // Pass-through
        t = blank_txn(); t.in = 1; t.rw = 1; t.r1 = 32'h1234;
        drive(t);
        #2;
        chk("pass_out", 32'(out_o), 1);
        chk("pass_r1", r1_o, 32'h1234);
        chk("pass_nostall", obs_stalls, 0);

        // Zero-wait signed byte load
        t = blank_txn(); t.in = 1; t.m2r = 1; t.rw = 1; t.byt = 1;
        t.r1 = 32'h103; t.rdata = 32'h80FF_FFFF;
        drive(t);
        chk("lb_be", 32'(obs_be), 32'h8);
        #2 chk("lb_memdata", md_o, 32'hFFFF_FF80);

        // Two-wait half store
        t = blank_txn(); t.in = 1; t.mw = 1; t.half = 1;
        t.r1 = 32'h202; t.rd2 = 32'hABCD_1234; t.w = 2;
        drive(t);
        chk("sh_stalls", obs_stalls, 2);
        chk("sh_be", 32'(obs_be), 32'hC);
        chk("sh_wdata", obs_wdata, 32'h1234_1234);
        #2 chk("sh_out", 32'(out_o), 1);

        // Unsigned half load
        t = blank_txn(); t.in = 1; t.m2r = 1; t.half = 1; t.uext = 1;
        t.r1 = 32'h0; t.rdata = 32'h0000_F00D; t.w = 1;
        drive(t);
        #2 chk("lhu_memdata", md_o, 32'h0000_F00D);

`ifdef MEM_MISALIGN_TRAP_EN
        t = blank_txn(); t.in = 1; t.m2r = 1; t.rw = 1; t.r1 = 32'h6; t.rdata = 32'hDEAD_BEEF;
        drive(t);
        #2;
        chk("trap_misalign", 32'(mis_o), 1);
        chk("trap_regwrite", 32'(rw_o), 0);
        chk("trap_out", 32'(out_o), 1);
`endif

        for (int i = 0; i < 300; i++) drive(rand_txn());

        // Reset while waiting on memory
        @(negedge clk);
        in_s = 1; m2r_in = 1; mw_in = 0; byte_in = 0; half_in = 0; r1_in = 32'h40;
        rw_in = 1; dm_ack = 0;
        #1 chk("wait_stall", 32'(stall), 1);
        z = last;
        z.out = 0; z.rw = 0; z.lo = 0; z.hi = 0; z.m2r = 0; z.mis = 0;
        exp_q.push_back(z);
        @(posedge clk);
        @(negedge clk);
        chk("wait_state", 32'(state_dbg), 32'(ST_WAIT));
        clr = 1'b1;
        #1 chk_all_zero("clr_wait");
        in_s = 0; dm_ack = 1;
        zero_last();
        exp_q.push_back(last);
        @(posedge clk);
        @(negedge clk) clr = 1'b0;
        t = blank_txn(); t.spur = 1; t.rw = 1; t.m2r = 1;
        drive(t);
        #2;
        chk("late_ack_out", 32'(out_o), 0);
        chk("late_ack_rw", 32'(rw_o), 0);
        chk("late_ack_state", 32'(state_dbg), 32'(ST_IDLE));

        @(negedge clk);
        dm_ack = 0;
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DATA_W, 32, data and address width; only 32 is supported.
REQ-002 Port clk  in  1  single clock; all state on rising edge.
REQ-003 Port CLR  in  1  reset, asynchronous, active-high.
REQ-004 Port In  in  1  EX/MEM valid bit.
REQ-005 Ports IR_in, PC_in, R1_in, R2_in, RD2_in  in  32 each  EX/MEM instruction, PC, ALU result/address, HI-side result, store data.
REQ-006 Port WbRegNum_in  in  5  destination register.
REQ-007 Ports RegWrite_in, LOWrite_in, HIWrite_in, MemtoReg_in, MemWrite_in, UnsignedExt_Mem_in, Byte_in, Half_in  in  1 each  EX/MEM control.
REQ-008 Port Stall  out  1  freeze request to the EX/MEM register and upstream stages.
REQ-009 Ports dm_req, dm_we  out  1 each; dm_addr  out  32 (bits 1:0 zero); dm_be  out  4; dm_wdata  out  32  data-memory request.
REQ-010 Ports dm_ack  in  1; dm_rdata  in  32  data-memory response, a full word.
REQ-011 Ports Out  out  1; IR, PC, R1, R2, MemData  out  32 each; WbRegNum  out  5; RegWrite, LOWrite, HIWrite, MemtoReg  out  1 each  registered MEM/WB bundle.

Function
REQ-012 An access SHALL be In=1 with MemtoReg_in=1 (load) or MemWrite_in=1 (store); all other valid instructions are pass-through.
REQ-013 The FSM SHALL have states IDLE and WAIT: IDLE->WAIT on an access without dm_ack; WAIT->IDLE on dm_ack.
REQ-014 dm_req SHALL be combinational: 1 in IDLE with an access pending, 1 throughout WAIT, else 0; dm_we=MemWrite_in while dm_req.
REQ-015 Stall SHALL equal dm_req AND NOT dm_ack; upstream holds all *_in stable while Stall=1.
REQ-016 Pass-through and zero-wait accesses SHALL have a latency of 1 clock: the MEM/WB bundle loads *_in on the next edge.
REQ-017 On the completing dm_ack edge the MEM/WB bundle SHALL load *_in, and MemData SHALL be the extended load lane (0 for stores).
REQ-018 On edges with Stall=1 the MEM/WB bundle SHALL load a bubble: Out, RegWrite, LOWrite, HIWrite, MemtoReg=0, data fields unchanged.
REQ-019 Lanes are little-endian; Byte: dm_be=1<<addr[1:0], dm_wdata={4{RD2_in[7:0]}}.
REQ-020 Half: dm_be=addr[1]?4'b1100:4'b0011, dm_wdata={2{RD2_in[15:0]}}; word: dm_be=4'b1111, dm_wdata=RD2_in.
REQ-021 Loads SHALL select the same lane; UnsignedExt_Mem_in=1 zero-extends, else sign-extends; word loads are unmodified.
REQ-022 dm_addr SHALL be {R1_in[31:2],2'b00}; ignored low bits (addr[0] for half, addr[1:0] for word) do not alter lanes.
REQ-023 dm_ack in IDLE with dm_req=0 SHALL be ignored.
REQ-024 In=0 SHALL produce Out=0 and all write enables 0 on the next edge, with no request issued.

Reset
REQ-025 CLR=1 SHALL immediately force state IDLE and all registered outputs (Out, IR, PC, R1, R2, MemData, WbRegNum, RegWrite, LOWrite, HIWrite, MemtoReg) to 0.
REQ-026 CLR asserted in WAIT SHALL abandon the access; dm_req follows the next access decode, and a late dm_ack is ignored per REQ-023.

Configuration
REQ-027 With MEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no request and produce port Misalign (out, 1, registered) =1 for one cycle alongside Out=1, with RegWrite/MemtoReg=0.
REQ-028 Without MEM_MISALIGN_TRAP_EN, no Misalign port SHALL exist and REQ-022 applies.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef, the byte-enable constants (BE_WORD, BE_HALF_LO, BE_HALF_HI) and the access-size encoding.
REQ-030 Lane select plus extension SHALL be the sub-module load_extend (in: rdata, addr[1:0], Byte, Half, UnsignedExt; out: 32-bit data).

Verification
REQ-031 Pass-through: In=1, RegWrite_in=1, R1_in=0x1234 -> next cycle Out=1, R1=0x1234, Stall never 1.
REQ-032 Zero-wait signed byte load: addr=0x103, dm_ack same cycle, dm_rdata=0x80FFFFFF -> dm_be=4'b1000, MemData=0xFFFFFF80.
REQ-033 Two-wait half store: addr=0x202, RD2_in=0xABCD1234, dm_ack after 2 cycles -> Stall=1 for 2 cycles, dm_be=4'b1100, dm_wdata=0x12341234, two bubbles then Out=1.
REQ-034 Unsigned half load: addr=0x0, dm_rdata=0x0000F00D -> MemData=0x0000F00D.
REQ-035 CLR pulsed in WAIT -> outputs 0 and state IDLE; a subsequent dm_ack with In=0 has no effect.
REQ-036 With MEM_MISALIGN_TRAP_EN, word access addr=0x6 -> dm_req stays 0, Misalign=1, RegWrite=0.
